mul_selftest_gen: RTL

Parametrised self-checking stimulus generator and checker for the team's multipliers (wallace_mul and its width variants).
- On start, it issues a fixed directed vector table and then a configurable number of LFSR pseudo-random operand pairs to an external multiplier DUT.
- It aligns a golden product to the DUT's pipeline latency, compares results, and reports pass/fail and error count.
- It sits at board top between sys_clk/rst_n and the DUT; its outputs feed ILA probes or LEDs.

---
 rtl/mul_st_pkg.sv | 37 +++
 rtl/mul_selftest_gen_if.sv | 24 ++
 rtl/mul_st_lfsr32.sv | 37 +++
 rtl/mul_selftest_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_st_pkg.sv
// mul_st_pkg: shared types and constants for the multiplier self-test.
// Holds the FSM states, directed vector table and LFSR polynomial.
package mul_st_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIR,
      ST_RAND,
      ST_DRAIN,
      ST_DONE
   } st_e;

   localparam int NDIR  = 10;
   localparam int CNT_W = 16;

   // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

   localparam logic [0:NDIR-1][31:0] DIR_A = {
      32'd11451, 32'd32000, 32'd0,    32'd1664,
      32'd211,   32'd10086, 32'd520,  32'd911,
      32'd231,   32'd8496
   };

   localparam logic [0:NDIR-1][31:0] DIR_B = {
      32'd250,   32'd11,    32'd850,  32'd2615,
      32'd985,   32'd12306, 32'd1314, 32'd110,
      32'd465,   32'd23512
   };

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mul_selftest_gen_if.sv
// mul_selftest_gen_if: operand/product bus between generator and multiplier.
// master = generator side, slave = multiplier under test.
interface mul_selftest_gen_if #(
   parameter int W = 16
);
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           op_valid;
   logic [2*W-1:0] dut_q;

   modport master (
      output op_a,
      output op_b,
      output op_valid,
      input  dut_q
   );

   modport slave (
      input  op_a,
      input  op_b,
      input  op_valid,
      output dut_q
   );
endinterface

// File: rtl/mul_st_lfsr32.sv
// mul_st_lfsr32: 32-bit Galois LFSR with seed reload and step enable.
module mul_st_lfsr32
   import mul_st_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   output logic [31:0] state
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = SEED;
      end else if (step) begin
         state_d = (state_q >> 1)
                 ^ (state_q[0] ? LFSR_POLY : 32'h0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/mul_selftest_gen.sv
// mul_selftest_gen: directed + LFSR vector generator and product checker.
// Define MUL_ST_ERR_CAPTURE_EN to expose the first mismatching vector.
module mul_selftest_gen
   import mul_st_pkg::*;
#(
   parameter int          W       = 16,
   parameter int          NRAND   = 64,
   parameter int          DUT_LAT = 0,
   parameter logic [31:0] SEED_A  = 32'hACE1_1234,
   parameter logic [31:0] SEED_B  = 32'h1357_9BDF
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic               start,
   mul_selftest_gen_if.master bus,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   vec_cnt
`ifdef MUL_ST_ERR_CAPTURE_EN
   ,
   output logic [W-1:0]       err_a,
   output logic [W-1:0]       err_b,
   output logic [2*W-1:0]     err_q
`endif
);

   localparam st_e AFTER_RAND =
      (DUT_LAT > 0) ? ST_DRAIN : ST_DONE;
   localparam st_e AFTER_DIR =
      (NRAND > 0) ? ST_RAND : AFTER_RAND;

`ifdef MUL_ST_ERR_CAPTURE_EN
   localparam int DW = 4 * W;
`else
   localparam int DW = 2 * W;
`endif

   st_e              state_q;
   logic [31:0]      idx_q;
   logic [W-1:0]     op_a_q;
   logic [W-1:0]     op_b_q;
   logic             op_v_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] err_cnt_d;
   logic [CNT_W-1:0] vec_cnt_q;
   logic [CNT_W-1:0] vec_cnt_d;

   logic             run_clr;
   logic [31:0]      lfsr_a;
   logic [31:0]      lfsr_b;
   logic [31:0]      dir_a;
   logic [31:0]      dir_b;
   logic [2*W-1:0]   exp_now;
   logic [DW-1:0]    d_now;
   logic [DW-1:0]    dly_d;
   logic             dly_v;
   logic             mism;
   logic             unused_bits;

   assign run_clr = start
                  & ((state_q == ST_IDLE)
                  |  (state_q == ST_DONE));

   mul_st_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .load  (run_clr),
      .step  (state_q == ST_RAND),
      .state (lfsr_a)
   );

   mul_st_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
      .clk   (sys_clk),
      .rst_n (rst_n),
      .load  (run_clr),
      .step  (state_q == ST_RAND),
      .state (lfsr_b)
   );

   assign dir_a = DIR_A[idx_q[3:0]];
   assign dir_b = DIR_B[idx_q[3:0]];
   assign unused_bits = ^{lfsr_a, lfsr_b, dir_a, dir_b};

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         op_v_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         op_a_q <= '0;
         op_b_q <= '0;
         op_v_q <= 1'b0;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_q <= ST_DIR;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else if (state_q == ST_DONE) begin
                  // err_cnt_d already holds the final compare
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  pass_q <= (err_cnt_d == '0);
               end
            end
            ST_DIR: begin
               op_a_q <= dir_a[W-1:0];
               op_b_q <= dir_b[W-1:0];
               op_v_q <= 1'b1;
               idx_q  <= idx_q + 32'd1;
               if (idx_q == 32'(NDIR - 1)) begin
                  idx_q   <= '0;
                  state_q <= AFTER_DIR;
               end
            end
            ST_RAND: begin
               op_a_q <= lfsr_a[W-1:0];
               op_b_q <= lfsr_b[W-1:0];
               op_v_q <= 1'b1;
               idx_q  <= idx_q + 32'd1;
               if (idx_q == 32'(NRAND - 1)) begin
                  idx_q   <= '0;
                  state_q <= AFTER_RAND;
               end
            end
            ST_DRAIN: begin
               idx_q <= idx_q + 32'd1;
               if (idx_q == 32'(DUT_LAT - 1)) begin
                  idx_q   <= '0;
                  state_q <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign exp_now = {{W{1'b0}}, op_a_q}
                  * {{W{1'b0}}, op_b_q};

`ifdef MUL_ST_ERR_CAPTURE_EN
   assign d_now = {op_a_q, op_b_q, exp_now};
`else
   assign d_now = exp_now;
`endif

   if (DUT_LAT == 0) begin : g_nodly
      assign dly_v = op_v_q;
      assign dly_d = d_now;
   end else begin : g_dly
      logic [DUT_LAT-1:0] v_sr;
      logic [DW-1:0]      d_sr [DUT_LAT];

      always_ff @(posedge sys_clk or negedge rst_n) begin
         if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < DUT_LAT; i++) begin
               d_sr[i] <= '0;
            end
         end else begin
            v_sr[0] <= op_v_q;
            d_sr[0] <= d_now;
            for (int i = 1; i < DUT_LAT; i++) begin
               v_sr[i] <= v_sr[i-1];
               d_sr[i] <= d_sr[i-1];
            end
         end
      end

      assign dly_v = v_sr[DUT_LAT-1];
      assign dly_d = d_sr[DUT_LAT-1];
   end

   assign mism = dly_v & (bus.dut_q != dly_d[2*W-1:0]);

   always_comb begin
      err_cnt_d = err_cnt_q;
      vec_cnt_d = vec_cnt_q;
      if (run_clr) begin
         err_cnt_d = '0;
         vec_cnt_d = '0;
      end else if (dly_v) begin
         vec_cnt_d = sat_inc(vec_cnt_q);
         if (mism) begin
            err_cnt_d = sat_inc(err_cnt_q);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
         vec_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         vec_cnt_q <= vec_cnt_d;
      end
   end

`ifdef MUL_ST_ERR_CAPTURE_EN
   logic [W-1:0]   ea_q;
   logic [W-1:0]   eb_q;
   logic [2*W-1:0] eq_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         ea_q <= '0;
         eb_q <= '0;
         eq_q <= '0;
      end else if (run_clr) begin
         ea_q <= '0;
         eb_q <= '0;
         eq_q <= '0;
      end else if (mism && err_cnt_q == '0) begin
         ea_q <= dly_d[4*W-1:3*W];
         eb_q <= dly_d[3*W-1:2*W];
         eq_q <= bus.dut_q;
      end
   end

   assign err_a = ea_q;
   assign err_b = eb_q;
   assign err_q = eq_q;
`endif

   assign bus.op_a     = op_a_q;
   assign bus.op_b     = op_b_q;
   assign bus.op_valid = op_v_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_cnt      = err_cnt_q;
   assign vec_cnt      = vec_cnt_q;

endmodule
